// File: rtl/resp_capture_log.sv
// Receive end of an exhaustive-vector test run: logs (vector, response) beats into a
// show-ahead FIFO, folds each accepted beat into a MISR and flags out-of-order vectors.
module resp_capture_log #(
  parameter int                VEC_W  = 3,
  parameter int                RESP_W = 1,
  parameter int                DEPTH  = 8,
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = 16'h002D
) (
  input  logic                       CK,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       cap_valid,
  input  logic [VEC_W-1:0]           cap_vec,
  input  logic [RESP_W-1:0]          cap_resp,
  output logic                       cap_ready,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [VEC_W-1:0]           rd_vec,
  output logic [RESP_W-1:0]          rd_resp,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [MISR_W-1:0]          signature,
  output logic                       done,
  output logic                       seq_err,
  output logic                       stall
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = VEC_W + RESP_W;
  localparam int IDX_W = VEC_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  // The session closes on the beat carrying index 2^VEC_W - 1.
  localparam logic [IDX_W-1:0] LAST_IDX = {1'b0, {VEC_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [MISR_W-1:0]  sig_r;
  logic               done_r;
  logic               seq_err_r;
  logic               stall_r;

  logic [ENT_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               cap_ready_s;
  logic               rd_valid_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic [ENT_W-1:0]   entry_s;
  logic [ENT_W-1:0]   head_s;

  // One MISR shift: feedback taps enter when the MSB leaves, then the beat is folded in.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic [ENT_W-1:0]  data);
    logic [MISR_W-1:0] fb;
    logic [MISR_W-1:0] ext;
    fb = sig[MISR_W-1] ? POLY : {MISR_W{1'b0}};
    ext = {MISR_W{1'b0}};
    ext[ENT_W-1:0] = data;
    return {sig[MISR_W-2:0], 1'b0} ^ fb ^ ext;
  endfunction

  assign full_s      = (count_r == FULL_CNT);
  assign cap_ready_s = (state_r == ST_CAPTURE) && (count_r < FULL_CNT);
  assign rd_valid_s  = (count_r != {CNT_W{1'b0}});
  assign push_s      = cap_valid && cap_ready_s;
  assign pop_s       = rd_valid_s && rd_ready;
  assign entry_s     = {cap_vec, cap_resp};
  assign head_s      = mem_r[rd_ptr_r];

  // Head presentation; forced to zero while empty so stale storage never leaks out.
  always_comb begin
    rd_vec  = {VEC_W{1'b0}};
    rd_resp = {RESP_W{1'b0}};
    if (rd_valid_s) begin
      {rd_vec, rd_resp} = head_s;
    end else begin
      rd_vec  = {VEC_W{1'b0}};
      rd_resp = {RESP_W{1'b0}};
    end
  end

  // Session FSM with signature, beat index and sticky status flags.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= {IDX_W{1'b0}};
      sig_r     <= {MISR_W{1'b0}};
      done_r    <= 1'b0;
      seq_err_r <= 1'b0;
      stall_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r   <= ST_CAPTURE;
            idx_r     <= {IDX_W{1'b0}};
            sig_r     <= {MISR_W{1'b0}};
            done_r    <= 1'b0;
            seq_err_r <= 1'b0;
            stall_r   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (push_s) begin
            idx_r <= idx_r + IDX_ONE;
            sig_r <= misr_step(sig_r, entry_s);
            if (cap_vec != idx_r[VEC_W-1:0]) begin
              seq_err_r <= 1'b1;
            end
            if (idx_r == LAST_IDX) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
          // A full FIFO refuses the beat; the source is expected to hold it.
          if (cap_valid && full_s) begin
            stall_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge CK) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge CK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  assign cap_ready = cap_ready_s;
  assign rd_valid  = rd_valid_s;
  assign count     = count_r;
  assign signature = sig_r;
  assign done      = done_r;
  assign seq_err   = seq_err_r;
  assign stall     = stall_r;

endmodule

// File: tb/tb_resp_capture_log.sv
// Directed bench for resp_capture_log: a queue-based behavioural model is checked every
// cycle, and literal expectations at key points pin the model itself.
module tb_resp_capture_log;

  localparam int DEPTH = 8;
  localparam int NBEATS = 8;

  logic        CK = 1'b0;
  logic        reset;
  logic        start;
  logic        cap_valid;
  logic [2:0]  cap_vec;
  logic        cap_resp;
  logic        cap_ready;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rd_vec;
  logic        rd_resp;
  logic [3:0]  count;
  logic [15:0] signature;
  logic        done;
  logic        seq_err;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  resp_capture_log dut (
    .CK(CK), .reset(reset), .start(start), .cap_valid(cap_valid), .cap_vec(cap_vec),
    .cap_resp(cap_resp), .cap_ready(cap_ready), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_vec(rd_vec), .rd_resp(rd_resp), .count(count), .signature(signature),
    .done(done), .seq_err(seq_err), .stall(stall)
  );

  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signature arithmetic: double, reduce by the polynomial on overflow, add in the beat.
  function automatic bit [15:0] model_misr(input bit [15:0] s, input bit [3:0] d);
    int t;
    t = int'(s) * 2;
    if (t >= 65536) t = (t - 65536) ^ 32'h0000_002D;
    return 16'(t) ^ {12'h000, d};
  endfunction

  // Model state: FIFO as a queue of {vec,resp}, session flag, beat counter, flags.
  bit [3:0]  q[$];
  bit        sess;
  int        m_idx;
  bit [15:0] m_sig;
  bit        m_done, m_seq, m_stall;
  bit        live = 1'b0;

  // Inputs change at negedge+1, so at negedge they are what the last posedge sampled.
  always @(negedge CK) begin
    int sz;
    bit acc, pp, was;
    bit [3:0] h;
    if (reset) begin
      q.delete();
      sess = 1'b0; m_idx = 0; m_sig = 16'h0000;
      m_done = 1'b0; m_seq = 1'b0; m_stall = 1'b0;
      live = 1'b1;
    end else if (live) begin
      sz  = q.size();
      was = sess;
      acc = cap_valid && sess && (sz < DEPTH);
      pp  = rd_ready && (sz > 0);
      if (sess && cap_valid && sz == DEPTH) m_stall = 1'b1;
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back({cap_vec, cap_resp});
        if (int'(cap_vec) != (m_idx % NBEATS)) m_seq = 1'b1;
        m_sig = model_misr(m_sig, {cap_vec, cap_resp});
        m_idx++;
        if (m_idx == NBEATS) begin
          sess = 1'b0;
          m_done = 1'b1;
        end
      end
      if (start && !was) begin
        sess = 1'b1; m_idx = 0; m_sig = 16'h0000;
        m_seq = 1'b0; m_stall = 1'b0; m_done = 1'b0;
      end
    end
    if (live) begin
      h = (q.size() != 0) ? q[0] : 4'h0;
      chk("model:cap_ready", 32'(cap_ready), 32'(sess && q.size() < DEPTH));
      chk("model:rd_valid",  32'(rd_valid),  32'(q.size() != 0));
      chk("model:rd_vec",    32'(rd_vec),    32'(h[3:1]));
      chk("model:rd_resp",   32'(rd_resp),   32'(h[0]));
      chk("model:count",     32'(count),     32'(q.size()));
      chk("model:signature", 32'(signature), 32'(m_sig));
      chk("model:done",      32'(done),      32'(m_done));
      chk("model:seq_err",   32'(seq_err),   32'(m_seq));
      chk("model:stall",     32'(stall),     32'(m_stall));
    end
  end

  task automatic drive(input logic v, input logic [2:0] vec, input logic r,
                       input logic rr, input logic st);
    cap_valid = v; cap_vec = vec; cap_resp = r; rd_ready = rr; start = st;
    @(negedge CK);
    #1;
  endtask

  task automatic run_in_order();
    logic [2:0] v3;
    for (int i = 0; i < NBEATS; i++) begin
      v3 = 3'(i);
      drive(1'b1, v3, v3[0], 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [2:0] v3;
    logic [2:0] skip_seq [8];
    skip_seq = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    reset = 1'b1; start = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
    cap_vec = 3'd0; cap_resp = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset:count", 32'(count), 32'd0);
    chk("reset:rd_valid", 32'(rd_valid), 32'd0);
    chk("reset:cap_ready", 32'(cap_ready), 32'd0);
    chk("reset:signature", 32'(signature), 32'd0);
    reset = 1'b0;

    // T1: full in-order session with the consumer always ready
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    chk("t1:cap_ready_after_start", 32'(cap_ready), 32'd1);
    run_in_order();
    chk("t1:done", 32'(done), 32'd1);
    chk("t1:signature", 32'(signature), 32'h004B);
    chk("t1:cap_ready_done", 32'(cap_ready), 32'd0);
    chk("t1:last_head", 32'(rd_vec), 32'd7);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("t1:drained", 32'(count), 32'd0);

    // T2: single beat from a zero signature, then fill the FIFO without reading
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("t2:done_cleared", 32'(done), 32'd0);
    drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("t2:signature", 32'(signature), 32'h000B);
    chk("t2:seq_err", 32'(seq_err), 32'd1);
    for (int i = 1; i < NBEATS; i++) begin
      v3 = 3'(i);
      drive(1'b1, v3, v3[0], 1'b0, 1'b0);
    end
    chk("t2:count_full", 32'(count), 32'd8);
    chk("t2:done", 32'(done), 32'd1);

    // T3: new session over a full FIFO of prior-session data
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("t3:cap_ready_full", 32'(cap_ready), 32'd0);
    chk("t3:count", 32'(count), 32'd8);
    drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("t3:stall", 32'(stall), 32'd1);
    chk("t3:count_held", 32'(count), 32'd8);
    drive(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    chk("t3:count_after_pop", 32'(count), 32'd7);
    chk("t3:cap_ready_reopen", 32'(cap_ready), 32'd1);
    chk("t3:head_after_pop", 32'(rd_vec), 32'd1);
    drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("t3:count_refill", 32'(count), 32'd8);
    chk("t3:signature", 32'(signature), 32'h0001);
    chk("t3:stall_sticky", 32'(stall), 32'd1);

    // T6: push+pop at count=8 (no push) and at count=3 (count holds, order kept)
    drive(1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
    chk("t6:no_push_full", 32'(count), 32'd7);
    chk("t6:sig_unchanged", 32'(signature), 32'h0001);
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("t6:count3", 32'(count), 32'd3);
    chk("t6:head6", 32'(rd_vec), 32'd6);
    drive(1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
    chk("t6:count_same", 32'(count), 32'd3);
    chk("t6:head7", 32'(rd_vec), 32'd7);
    drive(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    chk("t6:head0", 32'(rd_vec), 32'd0);
    chk("t6:head0_resp", 32'(rd_resp), 32'd1);

    // T5: reset mid-session after the fourth accepted beat
    drive(1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    drive(1'b1, 3'd4, 1'b0, 1'b1, 1'b1);
    chk("t5:count", 32'(count), 32'd0);
    chk("t5:rd_valid", 32'(rd_valid), 32'd0);
    chk("t5:rd_vec", 32'(rd_vec), 32'd0);
    chk("t5:signature", 32'(signature), 32'd0);
    chk("t5:stall", 32'(stall), 32'd0);
    chk("t5:cap_ready", 32'(cap_ready), 32'd0);
    reset = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    run_in_order();
    chk("t5:signature_again", 32'(signature), 32'h004B);
    chk("t5:done", 32'(done), 32'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // T4: vector 2 skipped, seq_err sticky until the next start
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NBEATS; i++) begin
      v3 = skip_seq[i];
      drive(1'b1, v3, 1'b0, 1'b1, 1'b0);
      if (i == 1) chk("t4:seq_err_before", 32'(seq_err), 32'd0);
      if (i == 2) chk("t4:seq_err_set", 32'(seq_err), 32'd1);
    end
    chk("t4:seq_err_sticky", 32'(seq_err), 32'd1);
    chk("t4:done", 32'(done), 32'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    chk("t4:seq_err_cleared", 32'(seq_err), 32'd0);
    chk("t4:done_cleared", 32'(done), 32'd0);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
